// File: rtl/plattform_pio_pkg.sv
// Shared definitions for the PIO input block.
// Holds the register offsets, the edge-mode codes and the debounce counter sizing helper.
package plattform_pio_pkg;

    typedef enum logic [1:0] {
        REG_DATA        = 2'd0,
        REG_RESERVED    = 2'd1,
        REG_IRQMASK     = 2'd2,
        REG_EDGECAPTURE = 2'd3
    } pioReg_e;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    // Bits needed to hold 0..cycles; the counter never exceeds cycles-1, so it cannot saturate.
    function automatic int counterWidth(input int cycles);
        int w;
        w = 1;
        while ((1 << w) < (cycles + 1)) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/plattform_pio_in_filter.sv
// Conditions one asynchronous input bit.
// It passes through a synchroniser chain, then an optional debounce window of DEBOUNCE_CYCLES.
module plattform_pio_in_filter
    import plattform_pio_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_async,
    output logic o_filtered
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_syncOut;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
        end
    end

    assign w_syncOut = r_sync[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign o_filtered = w_syncOut;
        end else begin : g_debounce
            localparam int               CNT_W = counterWidth(DEBOUNCE_CYCLES);
            localparam logic [CNT_W-1:0] LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] r_count;
            logic             r_filtered;

            // The new level is accepted on its Nth consecutive differing cycle; any agreement restarts the window.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    r_count    <= '0;
                    r_filtered <= 1'b0;
                end else if (w_syncOut == r_filtered) begin
                    r_count <= '0;
                end else if (r_count == LAST) begin
                    r_filtered <= w_syncOut;
                    r_count    <= '0;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end

            assign o_filtered = r_filtered;
        end
    endgenerate

endmodule

// File: rtl/plattform_pio_in_irq.sv
// Avalon-MM PIO input port with per-bit synchroniser/debounce, edge capture and a maskable level IRQ.
// Register map: DATA at offset 0, IRQMASK at offset 2, EDGECAPTURE at offset 3 (write 1 to clear).
module plattform_pio_in_irq
    import plattform_pio_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] w_filtered;
    logic [WIDTH-1:0] w_edgeSet;
    logic [WIDTH-1:0] w_capClear;
    logic             w_write;

    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_irqMask;
    logic [WIDTH-1:0] r_edgeCapture;
    logic [31:0]      r_readdata;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            plattform_pio_in_filter #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_filter (
                .clk        (clk),
                .reset_n    (reset_n),
                .i_async    (in_port[gi]),
                .o_filtered (w_filtered[gi])
            );
        end
    endgenerate

    assign w_write = chipselect && !write_n;

    always_comb begin
        case (EDGE_TYPE)
            EDGE_FALLING: w_edgeSet = ~w_filtered & r_prev;
            EDGE_ANY:     w_edgeSet = w_filtered ^ r_prev;
            default:      w_edgeSet = w_filtered & ~r_prev;
        endcase
    end

    assign w_capClear = (w_write && address == REG_EDGECAPTURE) ? writedata[WIDTH-1:0] : '0;

    // A bit being set on the same edge it is cleared stays set, so no edge is lost.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_prev        <= '0;
            r_irqMask     <= '0;
            r_edgeCapture <= '0;
        end else begin
            r_prev        <= w_filtered;
            r_edgeCapture <= (r_edgeCapture & ~w_capClear) | w_edgeSet;
            if (w_write && address == REG_IRQMASK) begin
                r_irqMask <= writedata[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            case (address)
                REG_DATA:        r_readdata <= 32'(w_filtered);
                REG_IRQMASK:     r_readdata <= 32'(r_irqMask);
                REG_EDGECAPTURE: r_readdata <= 32'(r_edgeCapture);
                default:         r_readdata <= '0;
            endcase
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_edgeCapture & r_irqMask);

endmodule

// File: tb/tb_plattform_pio_in_irq.sv
// Self-checking bench: three differently parameterised instances share one bus and are compared
// every cycle against a behavioural model, plus directed latency/boundary scenarios.
`timescale 1ns/1ps
module tb_plattform_pio_in_irq;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  inPort [NI];
    logic [31:0] rdA, rdB, rdC;
    logic        irqA, irqB, irqC;

    int checks = 0;
    int errors = 0;
    bit modelValid = 1'b0;

    // Model state: input sample history, synchronised samples seen since reset, register images.
    logic [7:0]  mHist    [NI][8];
    logic [7:0]  mSeen    [NI][8];
    int          mSeenCnt [NI];
    logic [7:0]  mFilt    [NI];
    logic [7:0]  mPrev    [NI];
    logic [7:0]  mMask    [NI];
    logic [7:0]  mCap     [NI];
    logic [31:0] mRead    [NI];

    always #5 clk = ~clk;

    plattform_pio_in_irq #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)) dutA (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(inPort[0]), .readdata(rdA), .irq(irqA));

    plattform_pio_in_irq #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) dutB (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(inPort[1]), .readdata(rdB), .irq(irqB));

    plattform_pio_in_irq #(.WIDTH(8), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .EDGE_TYPE(1)) dutC (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(inPort[2]), .readdata(rdC), .irq(irqC));

    function automatic int syncOf(input int i);
        case (i)
            0: return 2;
            1: return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int debOf(input int i);
        case (i)
            0: return 0;
            1: return 4;
            default: return 1;
        endcase
    endfunction

    function automatic int edgeOf(input int i);
        case (i)
            0: return 0;
            1: return 2;
            default: return 1;
        endcase
    endfunction

    function automatic logic [31:0] getRead(input int i);
        case (i)
            0: return rdA;
            1: return rdB;
            default: return rdC;
        endcase
    endfunction

    function automatic logic getIrq(input int i);
        case (i)
            0: return irqA;
            1: return irqB;
            default: return irqC;
        endcase
    endfunction

    // Without debounce the filtered level is just the input delayed by the synchroniser depth.
    function automatic logic [7:0] filtNow(input int i);
        if (debOf(i) == 0) return mHist[i][syncOf(i)-1];
        return mFilt[i];
    endfunction

    task automatic modelStep(input int i);
        logic [7:0] fBefore;
        logic [7:0] syncBefore;
        logic [7:0] setBits;
        logic [7:0] clrBits;
        bit         allDiffer;
        if (!reset_n) begin
            for (int k = 0; k < 8; k++) begin
                mHist[i][k] = 8'h00;
                mSeen[i][k] = 8'h00;
            end
            mSeenCnt[i] = 0;
            mFilt[i]    = 8'h00;
            mPrev[i]    = 8'h00;
            mMask[i]    = 8'h00;
            mCap[i]     = 8'h00;
            mRead[i]    = 32'h0;
            return;
        end
        fBefore    = filtNow(i);
        syncBefore = mHist[i][syncOf(i)-1];
        case (address)
            2'd0:    mRead[i] = {24'h0, fBefore};
            2'd2:    mRead[i] = {24'h0, mMask[i]};
            2'd3:    mRead[i] = {24'h0, mCap[i]};
            default: mRead[i] = 32'h0;
        endcase
        case (edgeOf(i))
            0:       setBits = fBefore & ~mPrev[i];
            1:       setBits = ~fBefore & mPrev[i];
            default: setBits = fBefore ^ mPrev[i];
        endcase
        clrBits = (chipselect && !write_n && address == 2'd3) ? writedata[7:0] : 8'h00;
        mCap[i] = (mCap[i] & ~clrBits) | setBits;
        if (chipselect && !write_n && address == 2'd2) mMask[i] = writedata[7:0];
        mPrev[i] = fBefore;
        // A bit flips once its last N synchronised samples since reset all disagreed with it.
        if (debOf(i) > 0) begin
            for (int k = 7; k > 0; k--) mSeen[i][k] = mSeen[i][k-1];
            mSeen[i][0] = syncBefore;
            if (mSeenCnt[i] < 8) mSeenCnt[i]++;
            for (int b = 0; b < 8; b++) begin
                allDiffer = (mSeenCnt[i] >= debOf(i));
                for (int k = 0; k < debOf(i); k++) begin
                    if (mSeen[i][k][b] == mFilt[i][b]) allDiffer = 1'b0;
                end
                if (allDiffer) mFilt[i][b] = ~mFilt[i][b];
            end
        end
        for (int k = 7; k > 0; k--) mHist[i][k] = mHist[i][k-1];
        mHist[i][0] = inPort[i];
    endtask

    always @(posedge clk) begin
        if (!reset_n) modelValid = 1'b1;
        for (int i = 0; i < NI; i++) modelStep(i);
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (modelValid) begin
            for (int i = 0; i < NI; i++) begin
                checkOutput($sformatf("model rd%0d", i), getRead(i), mRead[i]);
                checkOutput($sformatf("model irq%0d", i), 32'(getIrq(i)), 32'(|(mCap[i] & mMask[i])));
            end
        end
    end

    task automatic waitEdges(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic busWrite(input logic [1:0] addr, input logic [31:0] data);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = addr;
        writedata  = data;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic applyStimulus();
        chipselect = 1'($urandom_range(0, 1));
        write_n    = 1'($urandom_range(0, 1));
        address    = 2'($urandom_range(0, 3));
        writedata  = $urandom;
        reset_n    = ($urandom_range(0, 99) != 0);
        for (int i = 0; i < NI; i++) begin
            if ($urandom_range(0, 5) == 0) inPort[i] = inPort[i] ^ 8'($urandom_range(1, 255));
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = 32'h0;
        for (int i = 0; i < NI; i++) inPort[i] = 8'h00;
        waitEdges(3);
        reset_n = 1'b1;

        address = 2'd2; waitEdges(1); checkOutput("rstMaskA", rdA, 32'h0);
        address = 2'd3; waitEdges(1); checkOutput("rstCapA", rdA, 32'h0);
        checkOutput("rstIrqA", 32'(irqA), 32'h0);
        address = 2'd0; waitEdges(1); checkOutput("rstDataB", rdB, 32'h0);

        // Input change to DATA and EDGECAPTURE latency without debounce.
        inPort[0] = 8'h5A;
        waitEdges(2); checkOutput("dataEarly", rdA, 32'h0);
        waitEdges(1); checkOutput("dataLat", rdA, 32'h5A);
        address = 2'd3; waitEdges(1); checkOutput("capRise", rdA, 32'h5A);

        // Masked interrupt and write-1-to-clear behaviour.
        inPort[0] = 8'h00; waitEdges(4);
        busWrite(2'd3, 32'hFF);
        busWrite(2'd2, 32'h02);
        inPort[0] = 8'h02;
        waitEdges(2); checkOutput("irqEarly", 32'(irqA), 32'h0);
        waitEdges(1); checkOutput("irqSet", 32'(irqA), 32'h1);
        busWrite(2'd3, 32'h01); checkOutput("irqKeep", 32'(irqA), 32'h1);
        busWrite(2'd3, 32'h02); checkOutput("irqClr", 32'(irqA), 32'h0);

        // Rising edge on bit3 on the same edge as its clear.
        inPort[0] = 8'h0A; waitEdges(2);
        busWrite(2'd3, 32'h08);
        waitEdges(1); checkOutput("setWins", rdA, 32'h08);

        // Debounce of 4: a 3-cycle glitch is rejected, a held level passes after 7 edges.
        address = 2'd0; inPort[1] = 8'h01; waitEdges(3); inPort[1] = 8'h00;
        waitEdges(8); checkOutput("glitchData", rdB, 32'h0);
        address = 2'd3; waitEdges(1); checkOutput("glitchCap", rdB, 32'h0);
        address = 2'd0; inPort[1] = 8'h01;
        waitEdges(6); checkOutput("debEarly", rdB, 32'h0);
        waitEdges(1); checkOutput("debLat", rdB, 32'h1);

        // Any-edge mode: both toggles of bit7 are captured independently.
        busWrite(2'd3, 32'hFF);
        inPort[1] = 8'h81; waitEdges(10); checkOutput("anyRise", rdB, 32'h80);
        busWrite(2'd3, 32'h80);
        inPort[1] = 8'h01; waitEdges(10); checkOutput("anyFall", rdB, 32'h80);

        // Reset inside a debounce window, input held high across and after it.
        busWrite(2'd3, 32'hFF);
        address = 2'd0; inPort[1] = 8'h03; waitEdges(4);
        reset_n = 1'b0; waitEdges(1);
        checkOutput("rstMidData", rdB, 32'h0);
        checkOutput("rstMidIrqA", 32'(irqA), 32'h0);
        reset_n = 1'b1;
        waitEdges(6); checkOutput("relEarly", rdB, 32'h0);
        waitEdges(1); checkOutput("relData", rdB, 32'h03);
        address = 2'd3; waitEdges(1); checkOutput("relCap", rdB, 32'h03);

        for (int n = 0; n < 800; n++) begin
            applyStimulus();
            waitEdges(1);
        end
        reset_n = 1'b1;
        chipselect = 1'b0;
        waitEdges(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
